fnd_scan_controller: RTL and testbench
======================================

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 250, meaning the full-frame refresh rate in Hz.
REQ-003 SHALL have parameter NUM_DIGITS, default 4, meaning the number of digit positions (range 2..8).
REQ-004 SHALL have parameter NUM_PAGES, default 2, meaning the number of selectable display pages (range 1..4).
REQ-005 SHALL have parameter BLINK_FRAMES, default 125, meaning frames per blink half-period.
REQ-006 SHALL have port `clk  in  1  clock`; `reset  in  1`; reset is asynchronous and active-high.
REQ-007 SHALL have port `page_sel  in  PAGE_W  requested page`, where PAGE_W = max(1, clog2(NUM_PAGES)).
REQ-008 SHALL have port `digits_i  in  NUM_PAGES*NUM_DIGITS*4  hex nibbles`; page p, digit k sits at bits [(p*NUM_DIGITS+k)*4 +: 4]; digit 0 is the rightmost.
REQ-009 SHALL have port `dp_i  in  NUM_PAGES*NUM_DIGITS  per-digit decimal-point request`, indexed the same way as digits_i.
REQ-010 SHALL have port `dp_blink_en  in  1  blink all lit decimal points`.
REQ-011 SHALL have port `lz_blank_en  in  1  leading-zero suppression enable`.
REQ-012 SHALL have port `brightness  in  3  duty level 0..7`.
REQ-013 SHALL have port `fnd_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low`.
REQ-014 SHALL have port `fnd_comm  out  NUM_DIGITS  digit enables, active-low, at most one low`.
REQ-015 SHALL have port `frame_tick  out  1  one-cycle pulse at each frame start`.

Function
REQ-016 Prescaler SHALL count TICK_DIV = CLK_HZ/(SCAN_HZ*NUM_DIGITS*8) cycles (minimum 1) and emit one sub-slot tick per wrap.
REQ-017 A 3-bit sub-slot counter SHALL advance on each tick; on its 7->0 wrap, the digit index SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-018 On the digit index wrap to 0, the controller SHALL do all of the following in the same cycle: pulse frame_tick for exactly one clk cycle; latch page_sel into the active page (values >= NUM_PAGES are clamped to NUM_PAGES-1); latch brightness.
REQ-019 page_sel or brightness changes mid-frame SHALL have no effect until the next frame start; there SHALL be no torn frames.
REQ-020 Decode SHALL use these active-low codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, with the dp bit (bit 7) forced per REQ-022.
REQ-021 With lz_blank_en=1, digit k>0 SHALL be blanked (segments a..g = 1) when it and every more-significant digit of the active page are 0; digit 0 is never blanked, so all-zero input shows "0".
REQ-022 dp (bit 7) SHALL be 0 only when dp_i for the active digit is 1 AND (dp_blink_en=0 OR blink_phase=1); a blanked digit still honours dp.
REQ-023 blink_phase SHALL toggle every BLINK_FRAMES frame starts.
REQ-024 The selected digit's fnd_comm bit SHALL be 0 only while sub-slot <= latched brightness; all other bits SHALL be 1 (brightness=7 gives full duty, 0 gives 1/8 duty).
REQ-025 fnd_font and fnd_comm SHALL be registered with 1-cycle latency from the counter state, and SHALL change in the same cycle.
REQ-026 During every sub-slot with fnd_comm all 1, fnd_font SHALL be 8'hFF (ghosting guard).

Reset
REQ-027 While reset is asserted: fnd_comm = all 1; fnd_font = 8'hFF; frame_tick = 0; prescaler, sub-slot, digit index, frame counter and blink_phase = 0; active page = 0; latched brightness = 7.
REQ-028 After reset release, the first frame_tick SHALL occur at the first digit wrap; there SHALL be no pulse on the release itself.
REQ-029 Reset asserted mid-frame SHALL take effect immediately, with no partial-digit completion.

Structure
REQ-030 Package fnd_pkg SHALL hold the 16-entry font table, the FONT_BLANK (8'hFF) constant, and the PAGE_W/TICK_DIV derivation functions.
REQ-031 A sub-module fnd_font_rom (nibble -> 7-bit segment code, combinational) SHALL be instantiated once; all counters stay in the top.

Verification (CLK_HZ=12800, SCAN_HZ=100, NUM_DIGITS=4, NUM_PAGES=2, BLINK_FRAMES=2 -> TICK_DIV=4, frame = 128 cycles)
REQ-032 Page 0 = 4'h1,2,3,4 (digit 3..0), brightness=7 -> comm 1110/1101/1011/0111, each for 32 cycles; fonts 99/B0/A4/F9; frame_tick every 128 cycles.
REQ-033 Page 1 = 0,0,0,7 with lz_blank_en=1 -> digits 3..1 show FF, digit 0 shows F8; with all zeros -> FF, FF, FF, C0.
REQ-034 Toggle page_sel 0->1 at cycle 40 of a frame -> the page 0 pattern completes, and page 1 appears only after the next frame_tick.
REQ-035 brightness=1 -> each digit's comm is low for 8 of its 32 cycles (sub-slots 0-1), and the font is FF otherwise.
REQ-036 dp_i digit 2 =1 with dp_blink_en=1 -> bit 7 of digit 2 is low in frames 2-3, high in frames 0-1, repeating; assert reset at cycle 70 -> outputs go FF/1111 in the next cycle.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// font table, blank code and the parameter derivation helpers.
package fnd_pkg;

   localparam logic [7:0] FONT_BLANK = 8'hFF;

   // Active-low {dp,g,f,e,d,c,b,a}; dp is held off here and driven separately.
   localparam logic [7:0] FONT_TABLE [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic int page_w(input int num_pages);
      return (num_pages > 1) ? $clog2(num_pages) : 1;
   endfunction

   function automatic int tick_div(input int clk_hz, input int scan_hz, input int num_digits);
      int div;
      div = clk_hz / (scan_hz * num_digits * 8);
      return (div < 1) ? 1 : div;
   endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// Hex nibble to active-low a..g segment pattern.
module fnd_font_rom
   import fnd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = FONT_TABLE[nibble][6:0];
   end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed seven-segment scanner: 8 sub-slots per digit give a
// brightness duty; page and brightness are only sampled at frame start.
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int SCAN_HZ      = 250,
   parameter int NUM_DIGITS   = 4,
   parameter int NUM_PAGES    = 2,
   parameter int BLINK_FRAMES = 125,
   localparam int PAGE_W      = page_w(NUM_PAGES)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [PAGE_W-1:0]               page_sel,
   input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] digits_i,
   input  logic [NUM_PAGES*NUM_DIGITS-1:0] dp_i,
   input  logic                            dp_blink_en,
   input  logic                            lz_blank_en,
   input  logic [2:0]                      brightness,
   output logic [7:0]                      fnd_font,
   output logic [NUM_DIGITS-1:0]           fnd_comm,
   output logic                            frame_tick
);

   localparam int TICK_DIV = tick_div(CLK_HZ, SCAN_HZ, NUM_DIGITS);
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DIG_W    = $clog2(NUM_DIGITS);
   localparam int FC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [2:0]            sub_q, sub_d;
   logic [DIG_W-1:0]      digit_q, digit_d;
   logic [FC_W-1:0]       fcnt_q, fcnt_d;
   logic                  blink_q, blink_d;
   logic [PAGE_W-1:0]     page_q, page_d;
   logic [2:0]            bright_q, bright_d;
   logic [7:0]            font_q, font_d;
   logic [NUM_DIGITS-1:0] comm_q, comm_d;
   logic                  tick_q, tick_d;

   logic                  slot_tick, sub_wrap, frame_wrap, lit;
   logic [3:0]            page_nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] page_dp, lead_zero;
   logic [3:0]            nib_sel;
   logic [6:0]            seg;
   logic                  dp_sel, blank;

   fnd_font_rom u_font_rom (
      .nibble (nib_sel),
      .seg    (seg)
   );

   // View of the active page; digit k is a leading zero if it and all
   // more-significant digits are zero.
   always_comb begin
      page_dp = '0;
      for (int k = 0; k < NUM_DIGITS; k++) page_nib[k] = 4'h0;
      for (int p = 0; p < NUM_PAGES; p++) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (page_q == PAGE_W'(p)) begin
               page_nib[k] = digits_i[(p*NUM_DIGITS+k)*4 +: 4];
               page_dp[k]  = dp_i[p*NUM_DIGITS+k];
            end
         end
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         lead_zero[k] = 1'b1;
         for (int j = k; j < NUM_DIGITS; j++) begin
            if (page_nib[j] != 4'h0) lead_zero[k] = 1'b0;
         end
      end
      nib_sel = 4'h0;
      dp_sel  = 1'b0;
      blank   = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (digit_q == DIG_W'(k)) begin
            nib_sel = page_nib[k];
            dp_sel  = page_dp[k];
            blank   = lz_blank_en && (k != 0) && lead_zero[k];
         end
      end
   end

   always_comb begin
      presc_d  = presc_q;
      sub_d    = sub_q;
      digit_d  = digit_q;
      fcnt_d   = fcnt_q;
      blink_d  = blink_q;
      page_d   = page_q;
      bright_d = bright_q;

      slot_tick  = (presc_q == PRE_W'(TICK_DIV - 1));
      sub_wrap   = slot_tick && (sub_q == 3'd7);
      frame_wrap = sub_wrap && (digit_q == DIG_W'(NUM_DIGITS - 1));

      presc_d = slot_tick ? '0 : presc_q + 1'b1;
      if (slot_tick) sub_d = sub_q + 3'd1;
      if (sub_wrap) digit_d = frame_wrap ? '0 : digit_q + 1'b1;

      tick_d = frame_wrap;
      if (frame_wrap) begin
         page_d   = (int'(page_sel) >= NUM_PAGES) ? PAGE_W'(NUM_PAGES - 1) : page_sel;
         bright_d = brightness;
         if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end

      // Font is forced blank whenever no digit is enabled to avoid ghosting.
      lit    = (sub_q <= bright_q);
      comm_d = '1;
      font_d = FONT_BLANK;
      if (lit) begin
         for (int k = 0; k < NUM_DIGITS; k++) comm_d[k] = !(digit_q == DIG_W'(k));
         font_d = {~(dp_sel && (!dp_blink_en || blink_q)), blank ? 7'h7F : seg};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q  <= '0;
         sub_q    <= '0;
         digit_q  <= '0;
         fcnt_q   <= '0;
         blink_q  <= 1'b0;
         page_q   <= '0;
         bright_q <= 3'd7;
         font_q   <= FONT_BLANK;
         comm_q   <= '1;
         tick_q   <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         sub_q    <= sub_d;
         digit_q  <= digit_d;
         fcnt_q   <= fcnt_d;
         blink_q  <= blink_d;
         page_q   <= page_d;
         bright_q <= bright_d;
         font_q   <= font_d;
         comm_q   <= comm_d;
         tick_q   <= tick_d;
      end
   end

   assign fnd_font   = font_q;
   assign fnd_comm   = comm_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench: expected output runs are queued with the stimulus and a
// monitor pops one each time the display pattern changes.
module tb_fnd_scan_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [0:0]  page_sel;
   logic [31:0] digits_i;
   logic [7:0]  dp_i;
   logic        dp_blink_en, lz_blank_en;
   logic [2:0]  brightness;
   logic [7:0]  fnd_font;
   logic [3:0]  fnd_comm;
   logic        frame_tick;

   typedef struct packed {
      logic [3:0] comm;
      logic [7:0] font;
      int         len;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b1;

   fnd_scan_controller #(
      .CLK_HZ(12800), .SCAN_HZ(100), .NUM_DIGITS(4), .NUM_PAGES(2), .BLINK_FRAMES(2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .page_sel    (page_sel),
      .digits_i    (digits_i),
      .dp_i        (dp_i),
      .dp_blink_en (dp_blink_en),
      .lz_blank_en (lz_blank_en),
      .brightness  (brightness),
      .fnd_font    (fnd_font),
      .fnd_comm    (fnd_comm),
      .frame_tick  (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [7:0] f0, input logic [7:0] f1,
                             input logic [7:0] f2, input logic [7:0] f3, input bit dim);
      logic [7:0] f [4];
      logic [3:0] c;
      f = '{f0, f1, f2, f3};
      for (int k = 0; k < 4; k++) begin
         c = ~(4'b0001 << k);
         if (dim) begin
            exp_q.push_back('{c, f[k], 8});
            exp_q.push_back('{4'hF, 8'hFF, 24});
         end else begin
            exp_q.push_back('{c, f[k], 32});
         end
      end
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (frame_tick) return;
      end
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: no frame_tick within 300 cycles (t=%0t)", $time);
   endtask

   // Monitor: one scoreboard pop per change of the displayed pattern.
   logic [11:0] prev = 12'hFFF;
   int          run = 0;
   exp_t        cur;
   bit          have_cur = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if ({fnd_comm, fnd_font} !== prev) begin
            if (have_cur && cur.len != 0) chk("run_len", run, cur.len);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got comm=%b font=%h, nothing queued", fnd_comm, fnd_font);
               have_cur = 1'b0;
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
               chk("comm", {28'd0, fnd_comm}, {28'd0, cur.comm});
               chk("font", {24'd0, fnd_font}, {24'd0, cur.font});
            end
            prev = {fnd_comm, fnd_font};
            run = 1;
         end else begin
            run++;
         end
      end
   end

   int cyc = 0;
   int last_tick = -1;

   always @(negedge clk) begin
      cyc++;
      if (reset) last_tick = -1;
      else if (frame_tick) begin
         if (last_tick >= 0) chk("frame_period", cyc - last_tick, 128);
         last_tick = cyc;
      end
   end

   initial begin
      int n;
      page_sel    = 1'b0;
      digits_i    = 32'h0007_1234;
      dp_i        = 8'h00;
      dp_blink_en = 1'b0;
      lz_blank_en = 1'b1;
      brightness  = 3'd7;

      repeat (3) @(negedge clk);
      chk("reset_comm", {28'd0, fnd_comm}, 32'hF);
      chk("reset_font", {24'd0, fnd_font}, 32'hFF);
      chk("reset_tick", {31'd0, frame_tick}, 32'h0);

      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0);
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0);
      #1 reset = 1'b0;

      wait_tick();  // frame 1
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0);
      push_frame(8'hF8, 8'hFF, 8'hFF, 8'hFF, 1'b0);

      wait_tick();  // frame 2: page switch mid-frame must wait for frame 3
      repeat (40) @(negedge clk);
      page_sel = 1'b1;

      wait_tick();  // frame 3
      push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
      push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 1'b1);

      wait_tick();  // frame 4: brightness change takes effect in frame 5
      digits_i[31:16] = 16'h0000;
      brightness = 3'd1;

      wait_tick();  // frame 5
      page_sel    = 1'b0;
      brightness  = 3'd7;
      dp_i        = 8'h04;
      dp_blink_en = 1'b1;
      push_frame(8'h99, 8'hB0, 8'h24, 8'hF9, 1'b0);
      push_frame(8'h99, 8'hB0, 8'h24, 8'hF9, 1'b0);
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 1'b0);
      exp_q.push_back('{4'hE, 8'h99, 32});
      exp_q.push_back('{4'hD, 8'hB0, 32});
      exp_q.push_back('{4'hB, 8'hA4, 0});
      exp_q.push_back('{4'hF, 8'hFF, 0});
      exp_q.push_back('{4'hE, 8'h99, 32});
      exp_q.push_back('{4'hD, 8'hB0, 32});
      exp_q.push_back('{4'hB, 8'hA4, 32});
      exp_q.push_back('{4'h7, 8'hF9, 0});

      wait_tick();  // frame 6
      wait_tick();  // frame 7
      wait_tick();  // frame 8
      wait_tick();  // frame 9: reset in the middle of digit 2
      repeat (70) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midreset_comm", {28'd0, fnd_comm}, 32'hF);
      chk("midreset_font", {24'd0, fnd_font}, 32'hFF);
      chk("midreset_tick", {31'd0, frame_tick}, 32'h0);
      repeat (4) @(negedge clk);
      #1 reset = 1'b0;

      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n++;
         if (frame_tick) break;
      end
      chk("first_tick_after_reset", n, 128);
      mon_en = 1'b0;
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
